// File: rtl/exc_commit_unit.sv
// Exception/eret commit sequencer feeding CP0 at the MEM/WB boundary.
// Optional taken-exception counter enabled by EXC_CNT_EN.
module exc_commit_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_ds,
  input  logic [31:0] mem_addr,
  input  logic        f_adel_if,
  input  logic        f_ri,
  input  logic        f_sys,
  input  logic        f_bp,
  input  logic        f_ov,
  input  logic        f_adel_mem,
  input  logic        f_ades_mem,
  input  logic        mem_eret,
  input  logic        cp0_interupt,
  input  logic        cp0_exl,
  input  logic [31:0] cp0_epc,
  output logic        exc_pulse,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        eret_pulse,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] exc_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        live;
  logic        int_req;
  logic        sync_req;
  logic        exc_take;
  logic        eret_take;
  logic [4:0]  code_d;
  logic [31:0] bva_d;
  logic [31:0] epc_d;

  logic        exc_pulse_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_epc_q;
  logic        exc_bd_q;
  logic [31:0] exc_bva_q;
  logic        eret_pulse_q;
  logic        redir_valid_q;
  logic [31:0] redir_pc_q;

  assign live      = mem_valid & (state_q == IDLE);
  assign int_req   = cp0_interupt & ~cp0_exl;
  assign sync_req  = f_adel_if | f_ri | f_sys | f_bp
                   | f_ov | f_adel_mem | f_ades_mem;
  assign exc_take  = live & (int_req | sync_req);
  assign eret_take = live & mem_eret & ~(int_req | sync_req);
  assign epc_d     = mem_is_ds ? (mem_pc - 32'd4) : mem_pc;

  always_comb begin
    code_d = 5'd0;
    bva_d  = 32'h0;
    priority case (1'b1)
      int_req:    code_d = 5'd0;
      f_adel_if: begin
        code_d = 5'd4;
        bva_d  = mem_pc;
      end
      f_ri:       code_d = 5'd10;
      f_sys:      code_d = 5'd8;
      f_bp:       code_d = 5'd9;
      f_ov:       code_d = 5'd12;
      f_adel_mem: begin
        code_d = 5'd4;
        bva_d  = mem_addr;
      end
      f_ades_mem: begin
        code_d = 5'd5;
        bva_d  = mem_addr;
      end
      default: begin
        code_d = 5'd0;
        bva_d  = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (exc_take | eret_take) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush = 1'b0;
    if (state_q == FLUSH) flush = 1'b1;
  end

  // Strobes last one cycle; payload fields hold until the next commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exc_pulse_q   <= 1'b0;
      exc_code_q    <= 5'd0;
      exc_epc_q     <= 32'h0;
      exc_bd_q      <= 1'b0;
      exc_bva_q     <= 32'h0;
      eret_pulse_q  <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'h0;
    end else begin
      exc_pulse_q   <= exc_take;
      eret_pulse_q  <= eret_take;
      redir_valid_q <= exc_take | eret_take;
      if (exc_take) begin
        exc_code_q <= code_d;
        exc_epc_q  <= epc_d;
        exc_bd_q   <= mem_is_ds;
        exc_bva_q  <= bva_d;
        redir_pc_q <= EXC_VECTOR;
      end else if (eret_take) begin
        redir_pc_q <= cp0_epc;
      end
    end
  end

  assign exc_pulse      = exc_pulse_q;
  assign exc_code       = exc_code_q;
  assign exc_epc        = exc_epc_q;
  assign exc_bd         = exc_bd_q;
  assign exc_badvaddr   = exc_bva_q;
  assign eret_pulse     = eret_pulse_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;

`ifdef EXC_CNT_EN
  logic [31:0] cnt_exc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            cnt_exc_q <= 32'h0;
    else if (exc_pulse_q) cnt_exc_q <= cnt_exc_q + 32'd1;
  end

  assign exc_count = cnt_exc_q;
`else
  assign exc_count = 32'h0;
`endif

endmodule

// File: tb/tb_exc_commit_unit.sv
// Directed scoreboard bench for exc_commit_unit.
module tb_exc_commit_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_is_ds, mem_eret;
  logic [31:0] mem_pc, mem_addr, cp0_epc;
  logic        f_adel_if, f_ri, f_sys, f_bp, f_ov;
  logic        f_adel_mem, f_ades_mem;
  logic        cp0_interupt, cp0_exl;
  logic        exc_pulse, exc_bd, eret_pulse, flush, redirect_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr, redirect_pc, exc_count;

  int passes = 0;
  int total  = 0;
  int exp_cnt = 0;

  typedef struct {
    logic        exc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] bva;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] VEC = 32'hBFC00380;

  always #5 clk = ~clk;

  exc_commit_unit dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_is_ds(mem_is_ds), .mem_addr(mem_addr),
    .f_adel_if(f_adel_if), .f_ri(f_ri), .f_sys(f_sys),
    .f_bp(f_bp), .f_ov(f_ov),
    .f_adel_mem(f_adel_mem), .f_ades_mem(f_ades_mem),
    .mem_eret(mem_eret), .cp0_interupt(cp0_interupt),
    .cp0_exl(cp0_exl), .cp0_epc(cp0_epc),
    .exc_pulse(exc_pulse), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret_pulse(eret_pulse),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exc_count(exc_count)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr();
    mem_valid = 0; mem_pc = 0; mem_is_ds = 0; mem_addr = 0;
    f_adel_if = 0; f_ri = 0; f_sys = 0; f_bp = 0; f_ov = 0;
    f_adel_mem = 0; f_ades_mem = 0; mem_eret = 0;
    cp0_interupt = 0; cp0_exl = 0; cp0_epc = 0;
  endtask

  task automatic push_exc(logic [4:0] code, logic [31:0] epc,
                          logic bd, logic [31:0] bva);
    exp_t e;
    e.exc = 1'b1; e.code = code; e.epc = epc;
    e.bd = bd; e.bva = bva; e.rpc = VEC;
    sb.push_back(e);
`ifdef EXC_CNT_EN
    exp_cnt++;
`endif
  endtask

  task automatic push_eret(logic [31:0] rpc);
    exp_t e;
    e.exc = 1'b0; e.code = 0; e.epc = 0;
    e.bd = 0; e.bva = 0; e.rpc = rpc;
    sb.push_back(e);
  endtask

  // Compare the commit cycle against the oldest scoreboard entry.
  task automatic pop_cmp(string tag);
    exp_t e;
    chk({tag, "_rv"}, redirect_valid, 1);
    chk({tag, "_flush"}, flush, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_rpc"}, redirect_pc, e.rpc);
    chk({tag, "_excp"}, exc_pulse, 32'(e.exc));
    chk({tag, "_eretp"}, eret_pulse, 32'(!e.exc));
    if (e.exc) begin
      chk({tag, "_code"}, exc_code, 32'(e.code));
      chk({tag, "_epc"}, exc_epc, e.epc);
      chk({tag, "_bd"}, exc_bd, 32'(e.bd));
      chk({tag, "_bva"}, exc_badvaddr, e.bva);
    end
  endtask

  // Inputs already driven; capture at next edge, then check full flush window.
  task automatic commit(string tag);
    @(posedge clk); #1; clr();
    @(negedge clk);
    pop_cmp(tag);
    @(negedge clk);
    chk({tag, "_flush2"}, flush, 1);
    chk({tag, "_pulse2"}, exc_pulse, 0);
    chk({tag, "_rv2"}, redirect_valid, 0);
    @(negedge clk);
    chk({tag, "_flush3"}, flush, 0);
    chk({tag, "_cnt"}, exc_count, exp_cnt);
  endtask

  task automatic no_event(string tag);
    @(posedge clk); #1; clr();
    @(negedge clk);
    chk({tag, "_excp"}, exc_pulse, 0);
    chk({tag, "_rv"}, redirect_valid, 0);
    chk({tag, "_flush"}, flush, 0);
  endtask

  initial begin
    clr();
    rstn = 0;
    #12;
    chk("rst_excp", exc_pulse, 0);
    chk("rst_code", exc_code, 0);
    chk("rst_epc", exc_epc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_cnt", exc_count, 0);
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);

    mem_valid = 1; mem_pc = 32'h80001000; f_sys = 1;
    push_exc(5'd8, 32'h80001000, 0, 0);
    commit("sys");

    mem_valid = 1; mem_pc = 32'h80002004; mem_is_ds = 1; f_ov = 1;
    push_exc(5'd12, 32'h80002000, 1, 0);
    commit("ov_ds");

    mem_valid = 1; mem_pc = 32'h0; mem_is_ds = 1; f_ov = 1;
    push_exc(5'd12, 32'hFFFFFFFC, 1, 0);
    commit("epc_wrap");

    mem_valid = 1; mem_pc = 32'h80004000; mem_addr = 32'h3;
    f_ri = 1; f_ades_mem = 1;
    push_exc(5'd10, 32'h80004000, 0, 0);
    commit("ri_ades");

    mem_valid = 1; mem_pc = 32'h80004010; mem_addr = 32'h3;
    f_ades_mem = 1;
    push_exc(5'd5, 32'h80004010, 0, 32'h3);
    commit("ades");

    mem_valid = 1; mem_pc = 32'h80005000; f_adel_if = 1;
    f_adel_mem = 1; mem_addr = 32'h11;
    push_exc(5'd4, 32'h80005000, 0, 32'h80005000);
    commit("adel_if");

    mem_valid = 0; f_sys = 1; f_bp = 1; mem_eret = 1;
    cp0_interupt = 1;
    no_event("invalid");

    mem_valid = 1; cp0_interupt = 1; cp0_exl = 1;
    no_event("int_exl");

    mem_valid = 1; mem_pc = 32'h80006000; cp0_interupt = 1;
    f_bp = 1;
    push_exc(5'd0, 32'h80006000, 0, 0);
    commit("int_bp");

    mem_valid = 1; mem_pc = 32'h80006100; cp0_exl = 1; f_bp = 1;
    push_exc(5'd9, 32'h80006100, 0, 0);
    commit("bp_exl");

    mem_valid = 1; mem_pc = 32'h80007000; mem_eret = 1;
    cp0_epc = 32'h80003000;
    push_eret(32'h80003000);
    @(posedge clk); #1; clr();
    mem_valid = 1; mem_pc = 32'h80007004; f_sys = 1;
    @(negedge clk);
    pop_cmp("eret");
    chk("eret_code_hold", exc_code, 9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("eret_flush2", flush, 1);
    chk("eret_sys_ign1", exc_pulse, 0);
    @(posedge clk); #1; clr();
    @(negedge clk);
    chk("eret_sys_ign2", exc_pulse, 0);
    chk("eret_rv_ign", redirect_valid, 0);
    chk("eret_flush3", flush, 0);
    chk("eret_cnt", exc_count, exp_cnt);

    mem_valid = 1; mem_pc = 32'h80008000; mem_eret = 1; f_sys = 1;
    cp0_epc = 32'h12345678;
    push_exc(5'd8, 32'h80008000, 0, 0);
    commit("sys_beats_eret");

    mem_valid = 1; mem_pc = 32'h80009000; f_ov = 1;
    @(posedge clk); #1; clr();
    @(negedge clk);
    chk("mid_excp", exc_pulse, 1);
    chk("mid_flush", flush, 1);
    #2 rstn = 0;
    #1;
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_excp", exc_pulse, 0);
    chk("mid_rst_code", exc_code, 0);
    chk("mid_rst_epc", exc_epc, 0);
    chk("mid_rst_rv", redirect_valid, 0);
    chk("mid_rst_rpc", redirect_pc, 0);
    chk("mid_rst_cnt", exc_count, 0);
    exp_cnt = 0;
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);
    chk("post_rst_flush", flush, 0);
    chk("post_rst_excp", exc_pulse, 0);

    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_pc = 32'h8000A000 + 32'(i * 16); f_bp = 1;
      push_exc(5'd9, 32'h8000A000 + 32'(i * 16), 0, 0);
      commit("cnt_seq");
    end
    chk("cnt_final", exc_count, exp_cnt);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
